dma_timing_control: RTL and testbench

DMA_TIMING_CONTROL -- requirements
Module: dma_timing_control

---
 rtl/dma_pkg.sv | 28 ++
 rtl/dma_priority_arbiter.sv | 63 ++++++
 rtl/dma_timing_control.sv | 156 +++++++++++++++
 tb/tb_dma_timing_control.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/dma_pkg.sv
// ============================================================================
// Module  : dma_pkg
// Brief   : Shared state encoding and channel-count constants for DMA timing.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package dma_pkg;

    localparam int c_NUM_CH_DEFAULT = 4;

    typedef enum logic [2:0] {
        SI = 3'd0,
        S0 = 3'd1,
        S1 = 3'd2,
        S2 = 3'd3,
        S3 = 3'd4,
        S4 = 3'd5
    } dmaState_t;

    // Width of a channel index; a single channel still needs one bit.
    function automatic int chIdxWidth(input int numCh);
        return (numCh > 1) ? $clog2(numCh) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/dma_priority_arbiter.sv
// ============================================================================
// Module  : dma_priority_arbiter
// Brief   : Fixed / rotating priority resolver with its rotation pointer.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module dma_priority_arbiter
    import dma_pkg::*;
#(
    parameter int NUM_CH = c_NUM_CH_DEFAULT,
    parameter int CH_W   = chIdxWidth(NUM_CH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NUM_CH-1:0] pending,
    input  logic              rotateEn,
    input  logic              advance,
    input  logic [CH_W-1:0]   doneCh,
    output logic [CH_W-1:0]   grantCh,
    output logic              grantValid
);

    localparam logic [CH_W:0]   c_NUM  = (CH_W+1)'(NUM_CH);
    localparam logic [CH_W-1:0] c_LAST = CH_W'(NUM_CH - 1);

    logic [CH_W-1:0] r_pointer;
    logic [CH_W-1:0] w_base;
    logic [CH_W-1:0] w_nextPtr;

    // Fixed mode always starts the search at channel 0; the pointer just waits.
    assign w_base    = rotateEn ? r_pointer : '0;
    assign w_nextPtr = (doneCh == c_LAST) ? '0 : doneCh + 1'b1;

    // Walk offsets from farthest to nearest so the closest pending channel wins.
    always_comb begin
        logic [CH_W:0] sum;
        sum        = '0;
        grantCh    = '0;
        grantValid = 1'b0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            sum = {1'b0, w_base} + (CH_W+1)'(i);
            if (sum >= c_NUM) begin
                sum = sum - c_NUM;
            end
            if (pending[sum[CH_W-1:0]]) begin
                grantCh    = sum[CH_W-1:0];
                grantValid = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pointer <= '0;
        end else if (advance && rotateEn) begin
            r_pointer <= w_nextPtr;
        end
    end

endmodule

`default_nettype wire

// File: rtl/dma_timing_control.sv
// ============================================================================
// Module  : dma_timing_control
// Brief   : DMA bus-cycle sequencer: hold handshake, S1-S4 word timing, EOP.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module dma_timing_control
    import dma_pkg::*;
#(
    parameter int NUM_CH = c_NUM_CH_DEFAULT
) (
    input  logic              CLK,
    input  logic              RESET_N,
    input  logic [NUM_CH-1:0] DREQ,
    input  logic [NUM_CH-1:0] chMask,
    input  logic [NUM_CH-1:0] blockMode,
    input  logic              ctrlDisable,
    input  logic              rotatingPriority,
    input  logic              HLDA,
    input  logic              EOP_N,
    input  logic              tcReached,
    output logic              HRQ,
    output logic [NUM_CH-1:0] DACK,
    output logic              AEN,
    output logic              ADSTB,
    output logic              xferStrobe,
    output logic              loadAddr,
    output logic              updateCurrentAddressReg,
    output logic              updateCurrentWordCountReg,
    output logic              intEOP,
    output logic              programCondition
);

    localparam int CH_W = chIdxWidth(NUM_CH);

    dmaState_t         r_state;
    dmaState_t         w_nextState;
    logic [CH_W-1:0]   r_winner;
    logic [CH_W-1:0]   w_grantCh;
    logic              w_grantValid;
    logic              w_latchWinner;
    logic              w_rotate;
    logic              r_eopSeen;
    logic [NUM_CH-1:0] w_pending;

    assign w_pending = DREQ & ~chMask;

    dma_priority_arbiter #(
        .NUM_CH (NUM_CH),
        .CH_W   (CH_W)
    ) u_arbiter (
        .clk        (CLK),
        .rst_n      (RESET_N),
        .pending    (w_pending),
        .rotateEn   (rotatingPriority),
        .advance    (w_rotate),
        .doneCh     (r_winner),
        .grantCh    (w_grantCh),
        .grantValid (w_grantValid)
    );

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_state   <= SI;
            r_winner  <= '0;
            r_eopSeen <= 1'b0;
        end else begin
            r_state <= w_nextState;
            if (w_latchWinner) begin
                r_winner <= w_grantCh;
            end
            // An EOP seen mid-word is held until the word's S4 retires it.
            if (r_state == S1 || r_state == S2 || r_state == S3) begin
                r_eopSeen <= r_eopSeen | ~EOP_N;
            end else begin
                r_eopSeen <= 1'b0;
            end
        end
    end

    always_comb begin
        w_nextState               = r_state;
        w_latchWinner             = 1'b0;
        w_rotate                  = 1'b0;
        HRQ                       = 1'b0;
        DACK                      = '0;
        AEN                       = 1'b0;
        ADSTB                     = 1'b0;
        xferStrobe                = 1'b0;
        loadAddr                  = 1'b0;
        updateCurrentAddressReg   = 1'b0;
        updateCurrentWordCountReg = 1'b0;
        intEOP                    = 1'b0;
        programCondition          = 1'b0;
        case (r_state)
            SI: begin
                programCondition = 1'b1;
                if ((|w_pending) && !ctrlDisable) begin
                    w_nextState = S0;
                end
            end
            S0: begin
                HRQ = 1'b1;
                if (!w_grantValid) begin
                    w_nextState = SI;
                end else if (HLDA) begin
                    w_nextState   = S1;
                    w_latchWinner = 1'b1;
                end
            end
            S1: begin
                HRQ            = 1'b1;
                AEN            = 1'b1;
                ADSTB          = 1'b1;
                loadAddr       = 1'b1;
                DACK[r_winner] = 1'b1;
                w_nextState    = HLDA ? S2 : SI;
            end
            S2, S3: begin
                HRQ            = 1'b1;
                AEN            = 1'b1;
                xferStrobe     = 1'b1;
                DACK[r_winner] = 1'b1;
                if (!HLDA) begin
                    w_nextState = SI;
                end else begin
                    w_nextState = (r_state == S2) ? S3 : S4;
                end
            end
            S4: begin
                HRQ                       = 1'b1;
                AEN                       = 1'b1;
                DACK[r_winner]            = 1'b1;
                updateCurrentAddressReg   = 1'b1;
                updateCurrentWordCountReg = 1'b1;
                if (tcReached || !EOP_N || r_eopSeen) begin
                    intEOP      = 1'b1;
                    w_rotate    = 1'b1;
                    w_nextState = SI;
                end else if (blockMode[r_winner]) begin
                    w_nextState = S1;
                end else begin
                    w_rotate    = 1'b1;
                    w_nextState = SI;
                end
            end
            default: begin
                w_nextState = SI;
            end
        endcase
    end

endmodule

`default_nettype wire

// File: tb/tb_dma_timing_control.sv
// ============================================================================
// Module  : tb_dma_timing_control
// Brief   : Directed and randomized self-checking bench for dma_timing_control.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dma_timing_control;

    localparam int N = 4;

    logic         CLK = 1'b0;
    logic         RESET_N = 1'b0;
    logic [N-1:0] DREQ = '0;
    logic [N-1:0] chMask = '0;
    logic [N-1:0] blockMode = '0;
    logic         ctrlDisable = 1'b0;
    logic         rotatingPriority = 1'b0;
    logic         HLDA = 1'b0;
    logic         EOP_N = 1'b1;
    logic         tcReached = 1'b0;
    logic         HRQ, AEN, ADSTB, xferStrobe, loadAddr;
    logic         updateCurrentAddressReg, updateCurrentWordCountReg;
    logic         intEOP, programCondition;
    logic [N-1:0] DACK;

    int checks = 0;
    int errors = 0;
    int ptr    = 0;   // reference model: highest-priority channel in rotating mode

    always #5 CLK = ~CLK;

    dma_timing_control #(.NUM_CH(N)) dut (
        .CLK                       (CLK),
        .RESET_N                   (RESET_N),
        .DREQ                      (DREQ),
        .chMask                    (chMask),
        .blockMode                 (blockMode),
        .ctrlDisable               (ctrlDisable),
        .rotatingPriority          (rotatingPriority),
        .HLDA                      (HLDA),
        .EOP_N                     (EOP_N),
        .tcReached                 (tcReached),
        .HRQ                       (HRQ),
        .DACK                      (DACK),
        .AEN                       (AEN),
        .ADSTB                     (ADSTB),
        .xferStrobe                (xferStrobe),
        .loadAddr                  (loadAddr),
        .updateCurrentAddressReg   (updateCurrentAddressReg),
        .updateCurrentWordCountReg (updateCurrentWordCountReg),
        .intEOP                    (intEOP),
        .programCondition          (programCondition)
    );

    function automatic logic [12:0] outVec();
        return {HRQ, AEN, ADSTB, xferStrobe, loadAddr, updateCurrentAddressReg,
                updateCurrentWordCountReg, intEOP, programCondition, DACK};
    endfunction

    function automatic logic [12:0] expVec(input logic hrq, input logic aen, input logic adstb,
                                           input logic xs, input logic la, input logic upd,
                                           input logic ieop, input logic pc, input logic [3:0] dack);
        return {hrq, aen, adstb, xs, la, upd, upd, ieop, pc, dack};
    endfunction

    // First pending channel found walking upward from the priority base, modulo N.
    function automatic int modelWinner(input logic [3:0] pend, input int base);
        for (int i = 0; i < N; i++) begin
            if (pend[(base + i) % N]) return (base + i) % N;
        end
        return -1;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge CLK);
    endtask

    // Entered at a negedge in idle with requests already driven; returns at the idle negedge.
    task automatic doService(input int ch, input int nWords, input bit tcLast,
                             input int eopWord, input bit expEop);
        logic [3:0] dk;
        dk = 4'(1 << ch);
        tick();
        chk("holdRequest", 32'(outVec()), 32'(expVec(1, 0, 0, 0, 0, 0, 0, 0, 4'h0)));
        HLDA = 1'b1;
        for (int w = 0; w < nWords; w++) begin
            for (int c = 0; c < 4; c++) begin
                tick();
                if (c == 0) tcReached = 1'b0;
                chk($sformatf("word ch%0d w%0d c%0d", ch, w, c), 32'(outVec()),
                    32'(expVec(1, 1, c == 0, c == 1 || c == 2, c == 0, c == 3,
                               c == 3 && w == nWords - 1 && expEop, 0, dk)));
                if (c == 1 && w == eopWord) EOP_N = 1'b0;
                if (c == 2) begin
                    EOP_N     = 1'b1;
                    tcReached = tcLast && (w == nWords - 1);
                end
            end
        end
        tick();
        chk($sformatf("idleAfter ch%0d", ch), 32'(outVec()), 32'(expVec(0, 0, 0, 0, 0, 0, 0, 1, 4'h0)));
        HLDA      = 1'b0;
        tcReached = 1'b0;
        if (rotatingPriority) ptr = (ch + 1) % N;
    endtask

    initial begin
        int order [5] = '{0, 1, 2, 3, 0};
        int ch, n;
        logic [3:0] d, m, b;
        bit tcL;

        #3;
        chk("resetState", 32'(outVec()), 32'(expVec(0, 0, 0, 0, 0, 0, 0, 1, 4'h0)));
        tick();
        RESET_N = 1'b1;
        tick();
        chk("idleNoReq", 32'(outVec()), 32'(expVec(0, 0, 0, 0, 0, 0, 0, 1, 4'h0)));

        // Fixed priority picks channel 1 out of 1010, single word
        DREQ = 4'b1010;
        doService(1, 1, 0, -1, 0);

        // Rotating priority with everything requesting
        rotatingPriority = 1'b1;
        DREQ = 4'b1111;
        for (int s = 0; s < 5; s++) doService(order[s], 1, 0, -1, 0);

        // Block mode on channel 2, terminal count on the third word
        rotatingPriority = 1'b0;
        DREQ      = 4'b0100;
        blockMode = 4'b0100;
        doService(2, 3, 1, -1, 1);

        // External EOP in S2 of the second block word
        doService(2, 2, 0, 1, 1);
        blockMode = 4'b0000;

        // Controller disabled: request must not raise HRQ
        ctrlDisable = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("ctrlDisable", 32'(outVec()), 32'(expVec(0, 0, 0, 0, 0, 0, 0, 1, 4'h0)));
        end
        ctrlDisable = 1'b0;

        // HLDA withdrawn in S2: abort with no updates and no rotation
        rotatingPriority = 1'b1;
        tick();
        chk("abortS0", 32'(outVec()), 32'(expVec(1, 0, 0, 0, 0, 0, 0, 0, 4'h0)));
        HLDA = 1'b1;
        tick();
        chk("abortS1", 32'(outVec()), 32'(expVec(1, 1, 1, 0, 1, 0, 0, 0, 4'b0100)));
        tick();
        chk("abortS2", 32'(outVec()), 32'(expVec(1, 1, 0, 1, 0, 0, 0, 0, 4'b0100)));
        HLDA = 1'b0;
        tick();
        chk("abortIdle", 32'(outVec()), 32'(expVec(0, 0, 0, 0, 0, 0, 0, 1, 4'h0)));
        DREQ = 4'b1111;
        doService(modelWinner(4'hF, ptr), 1, 0, -1, 0);

        // Request withdrawn while waiting for HLDA
        rotatingPriority = 1'b0;
        DREQ = 4'b0001;
        tick();
        chk("dropS0", 32'(outVec()), 32'(expVec(1, 0, 0, 0, 0, 0, 0, 0, 4'h0)));
        DREQ = 4'b0000;
        tick();
        chk("dropIdle", 32'(outVec()), 32'(expVec(0, 0, 0, 0, 0, 0, 0, 1, 4'h0)));

        // Asynchronous reset in S3
        DREQ = 4'b1000;
        tick();
        HLDA = 1'b1;
        tick();
        tick();
        tick();
        chk("preResetS3", 32'(outVec()), 32'(expVec(1, 1, 0, 1, 0, 0, 0, 0, 4'b1000)));
        #2 RESET_N = 1'b0;
        #1 chk("asyncReset", 32'(outVec()), 32'(expVec(0, 0, 0, 0, 0, 0, 0, 1, 4'h0)));
        ptr  = 0;
        HLDA = 1'b0;
        DREQ = 4'b0000;
        tick();
        RESET_N = 1'b1;
        rotatingPriority = 1'b1;
        DREQ = 4'b1111;
        doService(modelWinner(4'hF, ptr), 1, 0, -1, 0);

        // Randomized traffic against the reference model
        for (int k = 0; k < 40; k++) begin
            do begin
                d = 4'($urandom_range(1, 15));
                m = 4'($urandom_range(0, 15));
            end while ((d & ~m) == 4'h0);
            b = 4'($urandom_range(0, 15));
            rotatingPriority = 1'($urandom_range(0, 1));
            DREQ      = d;
            chMask    = m;
            blockMode = b;
            ch  = modelWinner(d & ~m, rotatingPriority ? ptr : 0);
            n   = b[ch] ? int'($urandom_range(1, 3)) : 1;
            tcL = b[ch] ? 1'b1 : 1'($urandom_range(0, 1));
            doService(ch, n, tcL, -1, tcL);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
